seg_scan_display: RTL and testbench

Four-digit multiplexed seven-segment driver for the DDS frequency readout. It consumes the thousands/hundreds/tens/ones BCD digits produced by the theoretical-frequency stage and time-multiplexes them onto one shared segment bus with per-digit enables. It snapshots the digits once per scan frame so the display never tears. It also blanks leading zeros and shows a dash for any non-BCD digit.

---
 rtl/seg_scan_display.sv | 111 +++++++++++
 tb/tb_seg_scan_display.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// Four-digit multiplexed 7-segment driver: per-frame digit snapshot, leading-zero blanking, dash for non-BCD.
// Outputs are registered one clk behind the slot counter; free-running scan with no backpressure.
module seg_scan_display #(
    parameter int DIV        = 50000,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic [3:0] thou_the,
    input  logic [3:0] hund_the,
    input  logic [3:0] ten_the,
    input  logic [3:0] one_the,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [6:0]    SEG_INV = {7{ACTIVE_LOW}};
    localparam logic [3:0]    AN_INV  = {4{ACTIVE_LOW}};

    logic [CW-1:0] cnt;
    logic          tick;
    logic [1:0]    slot;
    logic [3:0]    lat_thou, lat_hund, lat_ten, lat_one;
    logic [3:0]    cur_dig;
    logic [3:0]    blank;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;

    assign tick = (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            slot <= '0;
        end else if (tick) begin
            cnt  <= '0;
            slot <= slot + 2'd1;
        end else begin
            cnt  <= cnt + CW'(1);
        end
    end

    // Capture on the last tick of a frame so all four slots of the next frame see one coherent value.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_thou <= '0;
            lat_hund <= '0;
            lat_ten  <= '0;
            lat_one  <= '0;
        end else if (tick && slot == 2'd3 && !hold) begin
            lat_thou <= thou_the;
            lat_hund <= hund_the;
            lat_ten  <= ten_the;
            lat_one  <= one_the;
        end
    end

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b0111111;
            4'd1:    decode = 7'b0000110;
            4'd2:    decode = 7'b1011011;
            4'd3:    decode = 7'b1001111;
            4'd4:    decode = 7'b1100110;
            4'd5:    decode = 7'b1101101;
            4'd6:    decode = 7'b1111101;
            4'd7:    decode = 7'b0000111;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1101111;
            default: decode = 7'b1000000;
        endcase
    endfunction

    // Blanking chains downward from thousands; a non-BCD digit is nonzero and breaks the chain.
    always_comb begin
        blank   = '0;
        cur_dig = lat_one;
        an_nxt  = '0;
        seg_nxt = '0;
        if (BLANK_LZ) begin
            blank[3] = (lat_thou == 4'd0);
            blank[2] = blank[3] && (lat_hund == 4'd0);
            blank[1] = blank[2] && (lat_ten == 4'd0);
        end
        case (slot)
            2'd0:    cur_dig = lat_one;
            2'd1:    cur_dig = lat_ten;
            2'd2:    cur_dig = lat_hund;
            default: cur_dig = lat_thou;
        endcase
        if (!blank[slot]) begin
            an_nxt  = 4'b0001 << slot;
            seg_nxt = decode(cur_dig);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= AN_INV;
            seg <= SEG_INV;
        end else begin
            an  <= an_nxt ^ AN_INV;
            seg <= seg_nxt ^ SEG_INV;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display with DIV=4: three instances (active-high, active-low, no blanking) on shared inputs.
module tb_seg_scan_display;

    localparam int DIV = 4;
    localparam int FRAME = 4 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       hold;
    logic [3:0] thou_the, hund_the, ten_the, one_the;
    logic [6:0] seg, seg_al, seg_nb;
    logic [3:0] an, an_al, an_nb;

    always #5 clk = ~clk;

    seg_scan_display #(.DIV(DIV), .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .thou_the(thou_the), .hund_the(hund_the), .ten_the(ten_the), .one_the(one_the),
        .seg(seg), .an(an)
    );

    seg_scan_display #(.DIV(DIV), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut_al (
        .clk(clk), .rst(rst), .hold(hold),
        .thou_the(thou_the), .hund_the(hund_the), .ten_the(ten_the), .one_the(one_the),
        .seg(seg_al), .an(an_al)
    );

    seg_scan_display #(.DIV(DIV), .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .hold(hold),
        .thou_the(thou_the), .hund_the(hund_the), .ten_the(ten_the), .one_the(one_the),
        .seg(seg_nb), .an(an_nb)
    );

    typedef struct packed {
        logic [15:0]     dig;    // {thou, hund, ten, one}
        logic [3:0][3:0] an_e;   // index = slot (0 = ones)
        logic [3:0][6:0] seg_e;
    } vec_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic [3:0] an_nb;
        logic [6:0] seg_nb;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[10];
    vec_t zero_v;
    vec_t shown;
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mkv(input logic [15:0] d,
                                 input logic [3:0] a3, input logic [3:0] a2,
                                 input logic [3:0] a1, input logic [3:0] a0,
                                 input logic [6:0] s3, input logic [6:0] s2,
                                 input logic [6:0] s1, input logic [6:0] s0);
        vec_t v;
        v.dig   = d;
        v.an_e  = {a3, a2, a1, a0};
        v.seg_e = {s3, s2, s1, s0};
        return v;
    endfunction

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%b want=%b", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] d);
        {thou_the, hund_the, ten_the, one_the} = d;
    endtask

    task automatic push_frame(input vec_t v);
        exp_t e;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < DIV; c++) begin
                e.an     = v.an_e[s];
                e.seg    = v.seg_e[s];
                e.an_nb  = 4'(1 << s);
                e.seg_nb = ref_seg(v.dig[4*s +: 4]);
                sb.push_back(e);
            end
        end
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty at %0t", $time);
        end else begin
            e = sb.pop_front();
            check("an",     {4'b0, an},     {4'b0, e.an});
            check("seg",    {1'b0, seg},    {1'b0, e.seg});
            check("an_al",  {4'b0, an_al},  {4'b0, ~e.an});
            check("seg_al", {1'b0, seg_al}, {1'b0, ~e.seg});
            check("an_nb",  {4'b0, an_nb},  {4'b0, e.an_nb});
            check("seg_nb", {1'b0, seg_nb}, {1'b0, e.seg_nb});
        end
    endtask

    // Drives junk (and the opposite hold) mid-frame; only the value present at the slot-3 tick may stick.
    task automatic run_frame(input vec_t v, input logic h);
        if (!h) shown = v;
        push_frame(shown);
        for (int c = 0; c < FRAME; c++) begin
            if (c == FRAME - 1) begin
                drive(v.dig);
                hold = h;
            end else if (c == 0 || c == 8) begin
                drive(16'($urandom));
                hold = ~h;
            end
            cyc();
        end
    endtask

    task automatic do_reset(input int n, input logic h);
        rst  = 1'b1;
        hold = h;
        drive(16'h5678);
        sb.delete();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_an",     {4'b0, an},     8'h00);
            check("rst_seg",    {1'b0, seg},    8'h00);
            check("rst_an_al",  {4'b0, an_al},  8'h0F);
            check("rst_seg_al", {1'b0, seg_al}, 8'h7F);
            check("rst_an_nb",  {4'b0, an_nb},  8'h00);
        end
        rst  = 1'b0;
        hold = 1'b0;
        shown = zero_v;
        push_frame(zero_v);
    endtask

    initial begin
        zero_v = mkv(16'h0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001,
                     7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111);
        tbl[0] = mkv(16'h1234, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
                     7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110);
        tbl[1] = mkv(16'h0039, 4'b0000, 4'b0000, 4'b0010, 4'b0001,
                     7'b0000000, 7'b0000000, 7'b1001111, 7'b1101111);
        tbl[2] = mkv(16'h0107, 4'b0000, 4'b0100, 4'b0010, 4'b0001,
                     7'b0000000, 7'b0000110, 7'b0111111, 7'b0000111);
        tbl[3] = mkv(16'hC000, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
                     7'b1000000, 7'b0111111, 7'b0111111, 7'b0111111);
        tbl[4] = mkv(16'h3906, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
                     7'b1001111, 7'b1101111, 7'b0111111, 7'b1111101);
        tbl[5] = mkv(16'h0008, 4'b0000, 4'b0000, 4'b0000, 4'b0001,
                     7'b0000000, 7'b0000000, 7'b0000000, 7'b1111111);
        tbl[6] = mkv(16'h00A5, 4'b0000, 4'b0000, 4'b0010, 4'b0001,
                     7'b0000000, 7'b0000000, 7'b1000000, 7'b1101101);
        tbl[7] = mkv(16'h9F00, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
                     7'b1101111, 7'b1000000, 7'b0111111, 7'b0111111);
        tbl[8] = mkv(16'h0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001,
                     7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111);
        tbl[9] = mkv(16'h8765, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
                     7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101);

        rst  = 1'b1;
        hold = 1'b0;
        drive(16'h1234);
        do_reset(3, 1'b0);

        for (int i = 0; i < 10; i++) run_frame(tbl[i], 1'b0);

        // Hold: 3906 latched, inputs switch to 0039 while held, then released.
        run_frame(tbl[4], 1'b0);
        for (int i = 0; i < 3; i++) run_frame(tbl[1], 1'b1);
        run_frame(tbl[1], 1'b0);
        run_frame(tbl[0], 1'b0);

        // Reset mid-scan with hold asserted: phase lost, snapshot cleared.
        for (int i = 0; i < 6; i++) cyc();
        do_reset(2, 1'b1);
        run_frame(tbl[2], 1'b0);
        run_frame(tbl[3], 1'b0);
        for (int i = 0; i < FRAME; i++) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
